boot_ctrl: RTL
==============

BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 512: number of instruction-memory words loaded per boot.
REQ-002 Parameter DMEM_WORDS, default 1024: number of data-memory words loaded per boot.
REQ-003 Parameter STOP_OPC, default 6'b111110: instruction opcode that halts the CPU.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a boot sequence.
REQ-007 s_valid  in  1  load-stream word valid.
REQ-008 s_data  in  32  load-stream word.
REQ-009 s_ready  out  1  load-stream word accepted when s_valid && s_ready.
REQ-010 instr_opc  in  6  opcode field [31:26] of the CPU's current instruction.
REQ-011 addr_ext, wdata_ext  out  32 each  instruction-memory external byte address / write data.
REQ-012 wen_ext, ren_ext  out  1 each  instruction-memory external write / read enable.
REQ-013 addr_ext_2, wdata_ext_2  out  32 each  data-memory external byte address / write data.
REQ-014 wen_ext_2, ren_ext_2  out  1 each  data-memory external write / read enable.
REQ-015 enable  out  1  CPU run enable.
REQ-016 busy  out  1  high in any state other than IDLE and HALT.
REQ-017 done  out  1  high in HALT.
REQ-018 cycle_count  out  32  number of cycles spent in RUN.

Function
REQ-019 FSM states: IDLE, LOAD_D, LOAD_I, SETTLE, RUN, HALT.
REQ-020 IDLE -> LOAD_D on start; start is ignored in LOAD_D, LOAD_I, SETTLE and RUN.
REQ-021 HALT -> LOAD_D on start; this restart zeroes the word index and cycle_count.
REQ-022 s_ready is 1 only in LOAD_D and LOAD_I; one word is accepted per handshake, with no back-pressure limit.
REQ-023 Stream order: the first DMEM_WORDS accepted words go to data memory, then IMEM_WORDS words go to instruction memory.
REQ-024 Word k of each region is written one cycle after acceptance: wen=1, addr = k<<2, wdata = the accepted word.
REQ-025 wen_ext / wen_ext_2 are 0 in any cycle not following an acceptance.
REQ-026 ren_ext and ren_ext_2 are held at 0.
REQ-027 Acceptance of data word DMEM_WORDS-1 moves LOAD_D -> LOAD_I and zeroes the index.
REQ-028 Acceptance of instruction word IMEM_WORDS-1 moves LOAD_I -> SETTLE.
REQ-029 SETTLE lasts exactly one cycle, absorbing the final write, then moves to RUN.
REQ-030 enable = 1 only in RUN; cycle_count increments by 1 on each RUN cycle and wraps 0xFFFFFFFF -> 0.
REQ-031 In RUN, instr_opc == STOP_OPC moves RUN -> HALT on the next edge; that RUN cycle is counted.
REQ-032 In HALT, enable = 0 and cycle_count is frozen.
REQ-033 Address and data outputs return to 0 whenever the matching wen is 0.
REQ-034 s_valid gaps stall the load without losing the index.
REQ-035 instr_opc is ignored outside RUN.

Reset
REQ-036 rst has priority over start and all other inputs in the same cycle.
REQ-037 rst in any state, including mid-load or RUN, goes to IDLE.
REQ-038 Reset values: all outputs 0, index 0, cycle_count 0; enable falls in the cycle after rst is sampled.
REQ-039 A partially loaded memory is not cleared by reset; the next boot overwrites it from word 0.

Verification (IMEM_WORDS=4, DMEM_WORDS=8)
REQ-040 Full boot: start, 12 back-to-back words 0x100..0x10B -> dmem writes addr 0x00..0x1C with data 0x100..0x107; imem writes addr 0x00..0x0C with data 0x108..0x10B; enable rises 2 cycles after the last handshake.
REQ-041 Stop detect: after 5 RUN cycles with opc 0, drive opc 6'b111110 -> HALT; enable=0, done=1, cycle_count=6.
REQ-042 Stall: s_valid toggles 1,0,0,1 each word -> same write sequence and addresses as REQ-040, no skipped or duplicated index.
REQ-043 Reset mid-load: rst after 3 dmem words -> IDLE next cycle, all outputs 0; a new start reloads from dmem addr 0x00.
REQ-044 Start while busy: start in LOAD_I and in RUN -> no state change, index continues; start in HALT -> LOAD_D with cycle_count=0.
REQ-045 Priority: rst and start asserted in the same cycle -> remains IDLE, s_ready=0.

Source files
------------

// File: rtl/boot_ctrl_if.sv
// Load-stream and external memory write bus between boot_ctrl and its environment.
interface boot_ctrl_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  logic [31:0] addr_ext;
  logic [31:0] wdata_ext;
  logic        wen_ext;
  logic        ren_ext;

  logic [31:0] addr_ext_2;
  logic [31:0] wdata_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;

  // Controller side: consumes the stream, drives both memory ports.
  modport master (
    input  s_valid, s_data,
    output s_ready,
    output addr_ext, wdata_ext, wen_ext, ren_ext,
    output addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2
  );

  // Environment side: produces the stream, observes both memory ports.
  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  addr_ext, wdata_ext, wen_ext, ren_ext,
    input  addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2
  );
endinterface

// File: rtl/boot_ctrl.sv
// Boot controller: streams data then instruction memory images in,
// releases the CPU, counts run cycles and halts on the stop opcode.
module boot_ctrl #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [5:0]  STOP_OPC   = 6'b111110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  instr_opc,
  output logic        enable,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_count,
  boot_ctrl_if.master bus
);

  localparam int unsigned MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int unsigned IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [IDX_W-1:0] DMEM_LAST = IDX_W'(DMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_I = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_ready_q, s_ready_d;
  logic             i_wen_q, i_wen_d;
  logic [31:0]      i_addr_q, i_addr_d;
  logic [31:0]      i_wdata_q, i_wdata_d;
  logic             d_wen_q, d_wen_d;
  logic [31:0]      d_addr_q, d_addr_d;
  logic [31:0]      d_wdata_q, d_wdata_d;
  logic             accept;

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
      i_wen_q   <= 1'b0;
      i_addr_q  <= '0;
      i_wdata_q <= '0;
      d_wen_q   <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
      i_wen_q   <= i_wen_d;
      i_addr_q  <= i_addr_d;
      i_wdata_q <= i_wdata_d;
      d_wen_q   <= d_wen_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  // Next state, word index, run counter and next values of all outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    // s_ready_q is high exactly in the load states, so it qualifies the handshake.
    accept    = bus.s_valid && s_ready_q;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = LOAD_D;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD_D: begin
        if (accept) begin
          if (idx_q == DMEM_LAST) begin
            state_d = LOAD_I;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      LOAD_I: begin
        if (accept) begin
          if (idx_q == IMEM_LAST) begin
            state_d = SETTLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      SETTLE: state_d = RUN;
      RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (instr_opc == STOP_OPC) begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory writes land one cycle after the handshake; bus idles at zero.
    d_wen_d   = accept && (state_q == LOAD_D);
    d_addr_d  = d_wen_d ? (32'(idx_q) << 2) : 32'd0;
    d_wdata_d = d_wen_d ? bus.s_data : 32'd0;
    i_wen_d   = accept && (state_q == LOAD_I);
    i_addr_d  = i_wen_d ? (32'(idx_q) << 2) : 32'd0;
    i_wdata_d = i_wen_d ? bus.s_data : 32'd0;

    s_ready_d = (state_d == LOAD_D) || (state_d == LOAD_I);
    enable_d  = (state_d == RUN);
    done_d    = (state_d == HALT);
    busy_d    = (state_d != IDLE) && (state_d != HALT);
  end

  assign enable          = enable_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cycle_count     = cnt_q;
  assign bus.s_ready     = s_ready_q;
  assign bus.addr_ext    = i_addr_q;
  assign bus.wdata_ext   = i_wdata_q;
  assign bus.wen_ext     = i_wen_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.addr_ext_2  = d_addr_q;
  assign bus.wdata_ext_2 = d_wdata_q;
  assign bus.wen_ext_2   = d_wen_q;
  assign bus.ren_ext_2   = 1'b0;

endmodule
